l2_arbiter: RTL and testbench
=============================

Name: l2_arbiter

Overview:
- Initiator on the L2 cache's arbiter-side port.
- Merges cacheline miss/writeback requests from the L1 instruction cache and the L1 data cache onto the single L2 request interface.
- Latches the granted request, holds it stable toward L2 until L2 asserts mem_resp, then routes the response back to the requesting L1.
- Round-robin fairness when both L1s request in the same cycle.

Parameters:
- ADDR_W, 16, address width (lc3b_word).
- LINE_W, 128, cacheline width (lc3b_cacheline).
- RST_FAVOR_D, 1, which client wins the first tie after reset (1 = dcache, 0 = icache).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  reset; asynchronous, active-low.
- i_read  in  1  icache read-line request; held until i_resp.
- i_write  in  1  icache write-line request; held until i_resp.
- i_address  in  ADDR_W  icache line address.
- i_wdata  in  LINE_W  icache write line.
- i_resp  out  1  one-cycle completion pulse to icache.
- i_rdata  out  LINE_W  read line to icache; valid only with i_resp.
- d_read, d_write, d_address, d_wdata, d_resp, d_rdata: same as the i_* ports, for the dcache.
- l2_read  out  1  request to L2 (drives L2 mem_read).
- l2_write  out  1  request to L2 (drives L2 mem_write).
- l2_address  out  ADDR_W  to L2 mem_address.
- l2_wdata  out  LINE_W  to L2 mem_wdata.
- l2_resp  in  1  L2 mem_resp.
- l2_rdata  in  LINE_W  L2 mem_rdata.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low.
- Reset values: state IDLE, last_grant set so the first tie goes to the client chosen by RST_FAVOR_D, latched op/address/wdata cleared. l2_read, l2_write, i_resp and d_resp are 0; l2_address and l2_wdata are 0.
- State machine: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - No L2 request is driven.
  - A client is pending if its read or write is asserted.
  - Only one client pending: grant it.
  - Both pending: grant the client not in last_grant.
  - On grant, latch the op (write has precedence if a client asserts read and write together; read is then ignored), address and wdata. Update last_grant. Go to BUSY_x on the next edge.
- BUSY_x:
  - l2_read/l2_write are driven from the latched op; l2_address and l2_wdata from the latched copies.
  - Outputs stay stable regardless of the client's inputs.
  - While l2_resp=0, stay in BUSY_x.
  - When l2_resp=1, x_resp=1 combinationally in the same cycle and x_rdata=l2_rdata. Return to IDLE on the next edge; l2 request outputs deassert there.
- Timing:
  - Added latency: 1 cycle (grant) before L2 sees the request.
  - There is 1 IDLE cycle between consecutive L2 transactions, so L2 always sees its request deassert between operations.
- Response routing: i_rdata and d_rdata may both mirror l2_rdata. Only the granted client's resp pulses. The other resp is 0 in every cycle.
- Client withdrawal: a client dropping its request during BUSY is a protocol violation. The latched transaction still completes, and resp still pulses to that client.
- Client re-request: a new request from the just-served client in the IDLE cycle after resp is legal. It competes under round-robin.
- l2_resp in IDLE: ignored, with no resp to any client.
- Reset asserted mid-transaction: immediate return to reset values. The L2 request is dropped and no resp is generated.

Decomposition:
- Shared package: lc3b_word and lc3b_cacheline (existing) in lc3b_types.
- Add lc3b_arb_state enum {IDLE, BUSY_I, BUSY_D} and lc3b_arb_client enum {ARB_I, ARB_D} to lc3b_types.
- One natural sub-module: l2_arbiter_req_latch, a registered op/address/wdata holder with a load enable.
- FSM and response routing stay in l2_arbiter.

Test Plan:
- icache-only read: i_read=1, i_address=16'h1230; L2 holds l2_resp 4 cycles later with l2_rdata=128'hA5..A5 -> l2_address=16'h1230 from cycle 1, l2_read=1 until resp, i_resp=1 one cycle with i_rdata=A5..A5, d_resp never 1.
- Simultaneous after reset with RST_FAVOR_D=1: i_read and d_write both asserted in cycle 0 -> dcache served first with l2_write=1 and l2_wdata=d_wdata; after d_resp, one IDLE cycle, then icache served.
- Sustained contention: both clients re-request immediately after each resp, 6 transactions -> grants strictly alternate D,I,D,I,D,I.
- Address change during BUSY_I: i_address switches 16'h1230 -> 16'h4440 mid-transaction -> l2_address stays 16'h1230 throughout; completes normally.
- Read and write together: d_read=1 and d_write=1 -> l2_write=1 and l2_read=0 throughout.
- Reset mid-transaction: reset_n low while BUSY_D -> l2_read, l2_write, d_resp and i_resp are 0 immediately without waiting for clk; after release, state IDLE and a fresh d_read is granted normally.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus the L2 arbiter's state, client encoding and
// round-robin pick function.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } lc3b_arb_state;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } lc3b_arb_client;

  // On a tie the client that was not served last wins.
  function automatic lc3b_arb_client rr_pick(input logic i_pend, input logic d_pend,
                                             input lc3b_arb_client last);
    lc3b_arb_client pick;
    if (i_pend && d_pend) pick = (last == ARB_D) ? ARB_I : ARB_D;
    else if (d_pend)      pick = ARB_D;
    else                  pick = ARB_I;
    return pick;
  endfunction

endpackage

// File: rtl/l2_arbiter_req_latch.sv
// Holds the granted request (op, address, write line) stable toward L2.
// Write takes precedence when a client raises read and write together.
module l2_arbiter_req_latch #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              o_read,
  output logic              o_write,
  output logic [ADDR_W-1:0] o_address,
  output logic [LINE_W-1:0] o_wdata
);

  logic              r_read;
  logic              r_write;
  logic [ADDR_W-1:0] r_address;
  logic [LINE_W-1:0] r_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_address <= '0;
      r_wdata   <= '0;
    end else if (i_load) begin
      r_write   <= i_write;
      r_read    <= i_read & ~i_write;
      r_address <= i_address;
      r_wdata   <= i_wdata;
    end
  end

  assign o_read    = r_read;
  assign o_write   = r_write;
  assign o_address = r_address;
  assign o_wdata   = r_wdata;

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin merge of icache/dcache line requests onto the single L2 port;
// one outstanding transaction, response routed back to the granted client.
module l2_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W      = $bits(lc3b_word),
  parameter int LINE_W      = $bits(lc3b_cacheline),
  parameter bit RST_FAVOR_D = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata,
  output lc3b_arb_state     o_dbg_state
);

  // last_grant starts as the opposite client so the first tie goes to the favoured one.
  localparam lc3b_arb_client RST_LAST = RST_FAVOR_D ? ARB_I : ARB_D;

  lc3b_arb_state  r_state;
  lc3b_arb_state  w_next_state;
  lc3b_arb_client r_last_grant;
  lc3b_arb_client w_pick;
  logic           w_i_pend;
  logic           w_d_pend;
  logic           w_grant;
  logic           w_sel_d;
  logic           w_busy;
  logic           w_lat_read;
  logic           w_lat_write;

  assign w_i_pend = i_read | i_write;
  assign w_d_pend = d_read | d_write;
  assign w_pick   = rr_pick(w_i_pend, w_d_pend, r_last_grant);
  assign w_sel_d  = (w_pick == ARB_D);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= RST_LAST;
    end else begin
      r_state <= w_next_state;
      if (w_grant) r_last_grant <= w_pick;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_i_pend || w_d_pend) begin
          w_grant      = 1'b1;
          w_next_state = w_sel_d ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I: begin
        if (l2_resp) begin
          i_resp       = 1'b1;
          w_next_state = IDLE;
        end
      end
      BUSY_D: begin
        if (l2_resp) begin
          d_resp       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  l2_arbiter_req_latch #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) u_req_latch (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_grant),
    .i_read    (w_sel_d ? d_read    : i_read),
    .i_write   (w_sel_d ? d_write   : i_write),
    .i_address (w_sel_d ? d_address : i_address),
    .i_wdata   (w_sel_d ? d_wdata   : i_wdata),
    .o_read    (w_lat_read),
    .o_write   (w_lat_write),
    .o_address (l2_address),
    .o_wdata   (l2_wdata)
  );

  // The latched op may linger after completion; only BUSY states drive it out.
  assign w_busy      = (r_state != IDLE);
  assign l2_read     = w_busy & w_lat_read;
  assign l2_write    = w_busy & w_lat_write;
  assign i_rdata     = l2_rdata;
  assign d_rdata     = l2_rdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: transaction-level model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_l2_arbiter;
  import lc3b_types::*;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_read, i_write, d_read, d_write;
  logic [ADDR_W-1:0] i_address, d_address;
  logic [LINE_W-1:0] i_wdata, d_wdata;
  logic              i_resp, d_resp;
  logic [LINE_W-1:0] i_rdata, d_rdata;
  logic              l2_read, l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic              l2_resp;
  logic [LINE_W-1:0] l2_rdata;
  lc3b_arb_state     o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // L2 responder controls
  int                lat = 4;
  int                cnt = 0;
  bit                stray = 1'b0;
  logic [LINE_W-1:0] next_data = '0;

  // Transaction-level model: 0 = no owner, 1 = icache, 2 = dcache
  int                m_owner = 0;
  logic              m_last_d = 1'b0;
  logic              m_rd = 1'b0, m_wr = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [LINE_W-1:0] m_wdata = '0;
  logic              m_pi, m_pd, m_take_d;

  logic [0:0] obs_q[$];
  logic [0:0] exp_q[$];

  l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .RST_FAVOR_D(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  assign m_pi     = i_read | i_write;
  assign m_pd     = d_read | d_write;
  assign m_take_d = m_pd && (!m_pi || !m_last_d);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner  <= 0;
      m_last_d <= 1'b0;  // dcache favoured: treat icache as last served
    end else if (m_owner == 0) begin
      if (m_pi || m_pd) begin
        m_owner  <= m_take_d ? 2 : 1;
        m_last_d <= m_take_d;
        m_wr     <= m_take_d ? d_write : i_write;
        m_rd     <= m_take_d ? (d_read & ~d_write) : (i_read & ~i_write);
        m_addr   <= m_take_d ? d_address : i_address;
        m_wdata  <= m_take_d ? d_wdata : i_wdata;
      end
    end else if (l2_resp) begin
      m_owner <= 0;
    end
  end

  // ---------------- L2 responder ----------------
  initial begin
    l2_resp  = 1'b0;
    l2_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n || l2_resp) begin
        l2_resp = 1'b0;
        cnt     = 0;
      end else if (stray) begin
        l2_resp  = 1'b1;
        l2_rdata = next_data;
      end else if (l2_read || l2_write) begin
        cnt = cnt + 1;
        if (cnt >= lat) begin
          l2_resp  = 1'b1;
          l2_rdata = next_data;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    lc3b_arb_state exp_st;
    logic busy;
    busy   = (m_owner != 0);
    exp_st = (m_owner == 0) ? IDLE : ((m_owner == 1) ? BUSY_I : BUSY_D);
    chk("state", o_dbg_state, exp_st);
    chk("l2_read", l2_read, busy && m_rd);
    chk("l2_write", l2_write, busy && m_wr);
    chk("i_resp", i_resp, (m_owner == 1) && l2_resp);
    chk("d_resp", d_resp, (m_owner == 2) && l2_resp);
    if (busy) begin
      chk("l2_address", l2_address, m_addr);
      chk("l2_wdata", l2_wdata, m_wdata);
    end
    if (i_resp) begin
      chk("i_rdata", i_rdata, l2_rdata);
      obs_q.push_back(1'b0);
    end
    if (d_resp) begin
      chk("d_rdata", d_rdata, l2_rdata);
      obs_q.push_back(1'b1);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_resp(input string name, input bit is_d, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (is_d ? d_resp : i_resp) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset_n = 1'b0;
    i_read = 0; i_write = 0; i_address = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;

    fork
      forever begin
        @(negedge clk);
        model_compare();
      end
    join_none

    // reset values
    repeat (2) step();
    @(negedge clk);
    chk("rst_state", o_dbg_state, IDLE);
    chk("rst_l2_read", l2_read, 1'b0);
    chk("rst_l2_address", l2_address, 16'h0000);
    chk("rst_l2_wdata", l2_wdata, 128'h0);
    step(); reset_n = 1'b1;
    step();

    // icache-only read, L2 answers in the 4th busy cycle
    lat = 4; next_data = {16{8'hA5}};
    i_read = 1; i_address = 16'h1230;
    @(negedge clk);
    chk("grant_cycle_l2_read", l2_read, 1'b0);
    @(negedge clk);
    chk("ird_l2_read", l2_read, 1'b1);
    chk("ird_l2_address", l2_address, 16'h1230);
    wait_resp("ird_timeout", 1'b0, 20);
    chk("ird_i_rdata", i_rdata, {16{8'hA5}});
    step(); i_read = 0;
    repeat (2) step();

    // simultaneous after reset: dcache favoured, then icache after one idle cycle
    reset_n = 1'b0; step(); reset_n = 1'b1; step();
    lat = 3; next_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    i_read = 1; i_address = 16'h2000;
    d_write = 1; d_address = 16'h3000; d_wdata = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
    wait_resp("sim_d_timeout", 1'b1, 20);
    chk("sim_d_l2_write", l2_write, 1'b1);
    chk("sim_d_l2_wdata", l2_wdata, 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D);
    step(); d_write = 0;
    @(negedge clk);
    chk("sim_gap_state", o_dbg_state, IDLE);
    chk("sim_gap_l2_read", l2_read, 1'b0);
    @(negedge clk);
    chk("sim_i_state", o_dbg_state, BUSY_I);
    chk("sim_i_l2_address", l2_address, 16'h2000);
    wait_resp("sim_i_timeout", 1'b0, 20);
    step(); i_read = 0;
    repeat (2) step();

    // sustained contention: grants alternate D,I,D,I,D,I
    obs_q.delete();
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    lat = 2; next_data = {8{16'h5A3C}};
    i_read = 1; i_address = 16'h7000;
    d_read = 1; d_address = 16'h8000;
    n = 0;
    for (int c = 0; c < 300 && n < 6; c++) begin
      @(negedge clk);
      if (i_resp || d_resp) n = n + 1;
    end
    chk("rr_count", n, 6);
    step(); i_read = 0; d_read = 0;
    chk("rr_len", obs_q.size(), 6);
    for (int k = 0; k < 6 && k < obs_q.size(); k++) chk("rr_order", obs_q[k], exp_q[k]);
    repeat (2) step();

    // address change while BUSY_I is ignored
    lat = 5; next_data = {4{32'h1357_9BDF}};
    i_read = 1; i_address = 16'h1230;
    repeat (3) step();
    i_address = 16'h4440;
    wait_resp("addr_chg_timeout", 1'b0, 20);
    chk("addr_chg_l2_address", l2_address, 16'h1230);
    step(); i_read = 0;
    repeat (2) step();

    // read and write together: write wins
    lat = 3; next_data = '0;
    d_read = 1; d_write = 1; d_address = 16'h5550; d_wdata = {8{16'hBEEF}};
    wait_resp("rw_timeout", 1'b1, 20);
    chk("rw_l2_write", l2_write, 1'b1);
    chk("rw_l2_read", l2_read, 1'b0);
    step(); d_read = 0; d_write = 0;
    repeat (2) step();

    // stray l2_resp while idle produces no client resp
    stray = 1'b1; step(); stray = 1'b0;
    @(negedge clk);
    chk("stray_l2_resp_seen", l2_resp, 1'b1);
    chk("stray_i_resp", i_resp, 1'b0);
    chk("stray_d_resp", d_resp, 1'b0);
    repeat (2) step();

    // reset during BUSY_D drops everything immediately
    lat = 10; next_data = {16{8'h3C}};
    d_read = 1; d_address = 16'h6660;
    repeat (3) step();
    chk("pre_rst_state", o_dbg_state, BUSY_D);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_l2_read", l2_read, 1'b0);
    chk("mid_rst_l2_write", l2_write, 1'b0);
    chk("mid_rst_d_resp", d_resp, 1'b0);
    chk("mid_rst_i_resp", i_resp, 1'b0);
    chk("mid_rst_state", o_dbg_state, IDLE);
    lat = 4;
    step(); step(); reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_state", o_dbg_state, IDLE);
    wait_resp("post_rst_timeout", 1'b1, 20);
    chk("post_rst_l2_address", l2_address, 16'h6660);
    chk("post_rst_d_rdata", d_rdata, {16{8'h3C}});
    step(); d_read = 0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
